// File: rtl/wb_eth_tx_fifo_if.sv
// rtl/wb_eth_tx_fifo_if.sv - Wishbone slave bus plus transmit stream bundle for wb_eth_tx_fifo
// Signals:
//   i_wb_cyc/i_wb_stb/i_wb_we/i_wb_addr/i_wb_data : pipelined Wishbone request
//   o_wb_ack/o_wb_stall/o_wb_data                  : Wishbone response
//   o_tx_valid/i_tx_ready/o_tx_data/o_tx_keep/o_tx_last : frame beat stream to the MAC
//   o_irq                                          : frame-complete pulse
// Modports: slave (the FIFO block), master (the bus/MAC side driving it).
interface wb_eth_tx_fifo_if #(
    parameter int DATA_W = 32
);
    localparam int BYTES = DATA_W / 8;

    logic              i_wb_cyc;
    logic              i_wb_stb;
    logic              i_wb_we;
    logic [1:0]        i_wb_addr;
    logic [DATA_W-1:0] i_wb_data;
    logic              o_wb_ack;
    logic              o_wb_stall;
    logic [DATA_W-1:0] o_wb_data;
    logic              o_tx_valid;
    logic              i_tx_ready;
    logic [DATA_W-1:0] o_tx_data;
    logic [BYTES-1:0]  o_tx_keep;
    logic              o_tx_last;
    logic              o_irq;

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_tx_ready,
        output o_wb_ack, o_wb_stall, o_wb_data,
        output o_tx_valid, o_tx_data, o_tx_keep, o_tx_last, o_irq
    );

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_tx_ready,
        input  o_wb_ack, o_wb_stall, o_wb_data,
        input  o_tx_valid, o_tx_data, o_tx_keep, o_tx_last, o_irq
    );
endinterface

// File: rtl/wb_eth_tx_fifo.sv
// rtl/wb_eth_tx_fifo.sv - Wishbone-fed transmit FIFO that streams committed Ethernet frames
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : wb_eth_tx_fifo_if.slave (Wishbone registers DATA/LEN/CTRL/STATUS, tx stream, irq)
// Registers (word address): 0 DATA (push, reads 0), 1 LEN (R/W), 2 CTRL (SEND/FLUSH/CLRERR,
// reads 0), 3 STATUS (busy, error, full, empty, fill level at bit 16).
module wb_eth_tx_fifo #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 9,
    parameter int LEN_W      = 11
) (
    input  logic              clk,
    input  logic              rst,
    wb_eth_tx_fifo_if.slave   bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int LW1   = LEN_W + 1;

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_next;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  fifo_full, fifo_empty;

    // Bus decode
    logic stall, accept, wr, rd;
    logic push, ctrl_wr, flush, send_cmd, clr_err;

    // Frame tracking
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] words_left;
    logic [BYTES-1:0] last_keep;
    logic             err;
    logic             tx_valid, pop, last_beat, frame_done;
    logic             load_frame, err_set;

    // Frame setup derived from the current LEN
    logic [LW1-1:0]   len_ext, rem;
    logic [LEN_W-1:0] words_calc;
    logic [BYTES-1:0] keep_calc;

    // Register read path
    logic [DATA_W-1:0] status, rdata_next;
    logic              ack_q, irq_q;
    logic [DATA_W-1:0] rdata_q;

    assign fifo_full  = (count == CNT_W'(DEPTH));
    assign fifo_empty = (count == '0);

    // Only a DATA write into a full FIFO is held off; everything else is accepted at once.
    assign stall    = bus.i_wb_cyc & bus.i_wb_stb & bus.i_wb_we & (bus.i_wb_addr == 2'd0) & fifo_full;
    assign accept   = bus.i_wb_cyc & bus.i_wb_stb & ~stall;
    assign wr       = accept & bus.i_wb_we;
    assign rd       = accept & ~bus.i_wb_we;
    assign push     = wr & (bus.i_wb_addr == 2'd0);
    assign ctrl_wr  = wr & (bus.i_wb_addr == 2'd2);
    assign flush    = ctrl_wr & bus.i_wb_data[1];
    // FLUSH in the same write suppresses SEND entirely (no error either).
    assign send_cmd = ctrl_wr & bus.i_wb_data[0] & ~bus.i_wb_data[1];
    assign clr_err  = ctrl_wr & bus.i_wb_data[2];

    assign tx_valid   = (state == SEND) & ~fifo_empty;
    // FLUSH beats a concurrent stream pop so the aborted beat is not counted as sent.
    assign pop        = tx_valid & bus.i_tx_ready & ~flush;
    assign last_beat  = (words_left == LEN_W'(1));
    assign frame_done = pop & last_beat;

    assign len_ext    = {1'b0, len};
    assign words_calc = LEN_W'((len_ext + LW1'(BYTES - 1)) / LW1'(BYTES));
    assign rem        = len_ext % LW1'(BYTES);

    always_comb begin
        keep_calc = '0;
        for (int i = 0; i < BYTES; i++) begin
            keep_calc[i] = (rem == '0) || (LW1'(i) < rem);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_frame = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (send_cmd) begin
                    if (len != '0) begin
                        state_next = SEND;
                        load_frame = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            SEND: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    if (send_cmd) begin
                        err_set = 1'b1;
                    end
                    if (frame_done) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        status                = '0;
        status[0]             = (state == SEND);
        status[1]             = err;
        status[2]             = fifo_full;
        status[3]             = fifo_empty;
        status[16 +: CNT_W]   = count;
    end

    always_comb begin
        rdata_next = '0;
        if (rd) begin
            case (bus.i_wb_addr)
                2'd1:    rdata_next = DATA_W'(len);
                2'd3:    rdata_next = status;
                default: rdata_next = '0;
            endcase
        end
    end

    // Storage is not reset; occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.i_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            len        <= '0;
            err        <= 1'b0;
            words_left <= '0;
            last_keep  <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            ack_q   <= accept;
            rdata_q <= rdata_next;
            irq_q   <= frame_done;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end

            if (wr && (bus.i_wb_addr == 2'd1)) begin
                len <= bus.i_wb_data[LEN_W-1:0];
            end

            if (err_set) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end

            // Beat count and final keep are captured at commit, so later LEN writes
            // only affect the next frame.
            if (load_frame) begin
                words_left <= words_calc;
                last_keep  <= keep_calc;
            end else if (pop) begin
                words_left <= words_left - LEN_W'(1);
            end
        end
    end

    assign bus.o_wb_stall = stall;
    assign bus.o_wb_ack   = ack_q;
    assign bus.o_wb_data  = rdata_q;
    assign bus.o_tx_valid = tx_valid;
    assign bus.o_tx_data  = mem[rd_ptr];
    assign bus.o_tx_keep  = last_beat ? last_keep : '1;
    assign bus.o_tx_last  = tx_valid & last_beat;
    assign bus.o_irq      = irq_q;
endmodule

// File: tb/tb_wb_eth_tx_fifo.sv
// tb/tb_wb_eth_tx_fifo.sv - scoreboard bench for wb_eth_tx_fifo with a queue-based frame model
module tb_wb_eth_tx_fifo;
    localparam int DW = 32;
    localparam int DL = 2;
    localparam int LW = 11;
    localparam int DEPTH = 1 << DL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_eth_tx_fifo_if #(.DATA_W(DW)) bus();

    wb_eth_tx_fifo #(.DATA_W(DW), .DEPTH_LOG2(DL), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] model_fifo[$];
    logic [31:0] exp_rd[$];
    int          model_len = 0;
    bit          model_err = 1'b0;
    int          irq_exp = 0;
    int          irq_seen = 0;
    int          rdy_mode = 0;
    int          pat = 0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Ready driver: 0 off, 1 on, 2 random, 3 pattern 1,0,0; 4 leaves ready to the main flow.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: bus.i_tx_ready = 1'b0;
            1: bus.i_tx_ready = 1'b1;
            2: bus.i_tx_ready = 1'($urandom_range(0, 1));
            3: begin
                bus.i_tx_ready = (pat % 3 == 0);
                pat++;
            end
            default: ;
        endcase
    end

    // Monitor: stream beats, bus responses and irq pulses, all sampled on the falling edge.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    always @(negedge clk) begin
        beat_t b;
        logic [31:0] e;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if ((rdy_mode == 2 || rdy_mode == 3) && prev_hold) begin
                check("hold_valid", 32'(bus.o_tx_valid), 32'd1);
                check("hold_data", bus.o_tx_data, prev_data);
            end
            prev_hold = bus.o_tx_valid && !bus.i_tx_ready;
            prev_data = bus.o_tx_data;
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                if (exp_beats.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    b = exp_beats.pop_front();
                    check("beat_data", bus.o_tx_data, b.data);
                    check("beat_keep", 32'(bus.o_tx_keep), 32'(b.keep));
                    check("beat_last", 32'(bus.o_tx_last), 32'(b.last));
                end
            end
            if (bus.o_wb_ack) begin
                if (exp_rd.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    e = exp_rd.pop_front();
                    check("wb_rdata", bus.o_wb_data, e);
                end
            end
            if (bus.o_irq) irq_seen++;
        end
    end

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        int fill;
        fill = model_fifo.size() + exp_beats.size();
        s = '0;
        s[0] = (exp_beats.size() != 0);
        s[1] = model_err;
        s[2] = (fill == DEPTH);
        s[3] = (fill == 0);
        s[16 +: DL+1] = (DL+1)'(fill);
        return s;
    endfunction

    task automatic start_frame();
        int n;
        int rem;
        logic [31:0] d;
        logic [3:0] k;
        n = (model_len + 3) / 4;
        rem = model_len % 4;
        for (int i = 0; i < n; i++) begin
            if (model_fifo.size() == 0) break;
            d = model_fifo.pop_front();
            k = 4'hF;
            if (i == n - 1 && rem != 0) k = 4'((1 << rem) - 1);
            exp_beats.push_back('{data: d, keep: k, last: (i == n - 1)});
        end
        irq_exp++;
    endtask

    task automatic model_ctrl(input logic [31:0] c);
        bit set_err;
        set_err = 1'b0;
        if (c[1]) begin
            model_fifo.delete();
            if (exp_beats.size() != 0) begin
                exp_beats.delete();
                irq_exp--;
            end
        end else if (c[0]) begin
            if (exp_beats.size() != 0 || model_len == 0) set_err = 1'b1;
            else start_frame();
        end
        if (set_err) model_err = 1'b1;
        else if (c[2]) model_err = 1'b0;
    endtask

    task automatic wb(input bit w, input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp_data);
        int n;
        @(posedge clk);
        #1;
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = w;
        bus.i_wb_addr = a;
        bus.i_wb_data = d;
        n = 0;
        @(negedge clk);
        while (bus.o_wb_stall && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("wb_stall_timeout");
        check("ack_early", 32'(bus.o_wb_ack), 32'd0);
        exp_rd.push_back(exp_data);
        @(posedge clk);
        #1;
        bus.i_wb_cyc = 1'b0;
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
        @(negedge clk);
        check("ack_latency", 32'(bus.o_wb_ack), 32'd1);
    endtask

    task automatic wr_data(input logic [31:0] d);
        model_fifo.push_back(d);
        wb(1'b1, 2'd0, d, 32'd0);
    endtask

    task automatic wr_len(input int l);
        model_len = l & ((1 << LW) - 1);
        wb(1'b1, 2'd1, 32'(l), 32'd0);
    endtask

    task automatic wr_ctrl(input logic [31:0] c);
        model_ctrl(c);
        wb(1'b1, 2'd2, c, 32'd0);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        logic [31:0] e;
        e = 32'd0;
        if (a == 2'd1) e = 32'(model_len);
        if (a == 2'd3) e = exp_status();
        wb(1'b0, a, $urandom, e);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (exp_beats.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            fail_now("frame_timeout");
            exp_beats.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w5;
        bus.i_wb_cyc   = 1'b0;
        bus.i_wb_stb   = 1'b0;
        bus.i_wb_we    = 1'b0;
        bus.i_wb_addr  = 2'd0;
        bus.i_wb_data  = '0;
        bus.i_tx_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ack", 32'(bus.o_wb_ack), 32'd0);
        check("rst_valid", 32'(bus.o_tx_valid), 32'd0);
        check("rst_irq", 32'(bus.o_irq), 32'd0);
        check("rst_rdata", bus.o_wb_data, 32'd0);
        rd_reg(2'd3);

        // Reset with the FIFO partly full and LEN set
        wr_data(32'hDEAD0001);
        wr_data(32'hDEAD0002);
        wr_len(10);
        rd_reg(2'd3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_fifo.delete();
        exp_beats.delete();
        model_len = 0;
        model_err = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 32'(bus.o_tx_valid), 32'd0);
        rd_reg(2'd3);
        rd_reg(2'd1);

        // Basic frame
        rdy_mode = 1;
        wr_data(32'h11223344);
        wr_data(32'h55667788);
        wr_data(32'h99AABBCC);
        wr_len(10);
        wr_ctrl(32'd1);
        wait_frame();
        rd_reg(2'd3);

        // Backpressure with ready pattern 1,0,0
        rdy_mode = 3;
        wr_data(32'h11223344);
        wr_data(32'h55667788);
        wr_data(32'h99AABBCC);
        wr_len(10);
        wr_ctrl(32'd1);
        wait_frame();
        rd_reg(2'd3);

        // Full FIFO stalls a DATA write until a beat drains
        rdy_mode = 4;
        bus.i_tx_ready = 1'b0;
        wr_len(16);
        for (int i = 0; i < 4; i++) wr_data(32'hA0000000 + 32'(i));
        wr_ctrl(32'd1);
        rd_reg(2'd3);
        w5 = 32'hA5A5A5A5;
        model_fifo.push_back(w5);
        @(posedge clk);
        #1;
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b1;
        bus.i_wb_addr = 2'd0;
        bus.i_wb_data = w5;
        @(negedge clk);
        check("stall_full", 32'(bus.o_wb_stall), 32'd1);
        @(posedge clk);
        #1 bus.i_tx_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_drop", 32'(bus.o_wb_stall), 32'd0);
        exp_rd.push_back(32'd0);
        @(posedge clk);
        #1;
        bus.i_wb_cyc   = 1'b0;
        bus.i_wb_stb   = 1'b0;
        bus.i_wb_we    = 1'b0;
        bus.i_tx_ready = 1'b0;
        @(negedge clk);
        check("stall_ack", 32'(bus.o_wb_ack), 32'd1);
        rd_reg(2'd3);
        rdy_mode = 1;
        wait_frame();
        rd_reg(2'd3);
        wr_len(4);
        wr_ctrl(32'd1);
        wait_frame();

        // Error handling
        wr_len(0);
        wr_ctrl(32'd1);
        rd_reg(2'd3);
        wr_ctrl(32'd4);
        rd_reg(2'd3);
        rdy_mode = 0;
        wr_len(8);
        wr_data(32'hC0FFEE01);
        wr_data(32'hC0FFEE02);
        wr_ctrl(32'd1);
        wr_len(4);
        wr_ctrl(32'd1);
        rd_reg(2'd3);
        rdy_mode = 3;
        wait_frame();
        wr_ctrl(32'd4);
        rd_reg(2'd3);
        rd_reg(2'd1);

        // Flush mid-frame
        rdy_mode = 4;
        bus.i_tx_ready = 1'b0;
        wr_len(16);
        for (int i = 0; i < 4; i++) wr_data(32'hF1000000 + 32'(i));
        wr_ctrl(32'd1);
        @(posedge clk);
        #1 bus.i_tx_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 bus.i_tx_ready = 1'b0;
        wr_ctrl(32'd2);
        check("flush_valid", 32'(bus.o_tx_valid), 32'd0);
        rd_reg(2'd3);
        rd_reg(2'd1);
        repeat (5) @(negedge clk);
        wr_data(32'h0BADF00D);
        wr_data(32'h12345678);
        wr_len(7);
        rdy_mode = 1;
        wr_ctrl(32'd1);
        wait_frame();
        rd_reg(2'd3);

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            int len;
            int n;
            len = $urandom_range(1, 16);
            n = (len + 3) / 4;
            rdy_mode = 0;
            for (int i = 0; i < n; i++) wr_data($urandom);
            wr_len(len);
            rdy_mode = $urandom_range(1, 3);
            wr_ctrl(32'd1);
            wait_frame();
            rd_reg(2'd3);
        end

        // SEND together with FLUSH: flush only, no frame, no error
        rdy_mode = 1;
        wr_data(32'h77777777);
        wr_len(4);
        wr_ctrl(32'd3);
        repeat (4) @(negedge clk);
        rd_reg(2'd3);

        repeat (5) @(negedge clk);
        check("irq_count", 32'(irq_seen), 32'(irq_exp));
        check("beats_left", 32'(exp_beats.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
